// File: rtl/bin_to_bcd_seq_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter and its display-side consumers.
// Holds FSM encoding, the BCD nine nibble, default widths and a constant power-of-ten helper.
package bin_to_bcd_seq_pkg;

   localparam int unsigned DEF_BIN_W  = 32;
   localparam int unsigned DEF_DIGITS = 8;
   localparam logic [3:0]  BCD_NINE   = 4'h9;

   // Width used for the 10^DIGITS limit so the overflow compare never truncates.
   localparam int unsigned POW_W = 128;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   function automatic logic [POW_W-1:0] pow10(input int unsigned n);
      logic [POW_W-1:0] r;
      r = POW_W'(1);
      for (int unsigned i = 0; i < n; i++) begin
         r = r * POW_W'(10);
      end
      return r;
   endfunction

endpackage

// File: rtl/bin_to_bcd_seq_if.sv
// Request/result bundle between the counter side (master) and the converter (slave).
interface bin_to_bcd_seq_if
   import bin_to_bcd_seq_pkg::*;
#(
   parameter int unsigned BIN_W  = DEF_BIN_W,
   parameter int unsigned DIGITS = DEF_DIGITS
);

   logic [BIN_W-1:0]    bin_in;
   logic                start;
   logic [4*DIGITS-1:0] bcd_out;
   logic                busy;
   logic                done;
   logic                ovf;

   modport master (
      output bin_in,
      output start,
      input  bcd_out,
      input  busy,
      input  done,
      input  ovf
   );

   modport slave (
      input  bin_in,
      input  start,
      output bcd_out,
      output busy,
      output done,
      output ovf
   );

endinterface

// File: rtl/bin_to_bcd_seq_dd_digit_adj.sv
// Double-dabble nibble correction: add 3 to any digit of 5 or more before the next shift.
module dd_digit_adj (
   input  logic [3:0] i_nib,
   output logic [3:0] o_nib
);

   assign o_nib = (i_nib >= 4'd5) ? (i_nib + 4'd3) : i_nib;

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble converter: one shift per clock, result register updated only at the end.
// Inputs at or above 10^DIGITS saturate to all nines and set ovf.
module bin_to_bcd_seq
   import bin_to_bcd_seq_pkg::*;
#(
   parameter int unsigned BIN_W        = DEF_BIN_W,
   parameter int unsigned DIGITS       = DEF_DIGITS,
   parameter bit          AUTO_RESTART = 1'b0
) (
   input  logic                clk,
   input  logic                rst,
   bin_to_bcd_seq_if.slave     bus
);

   localparam int unsigned      BCD_W = 4 * DIGITS;
   localparam int unsigned      CNT_W = $clog2(BIN_W + 1);
   localparam logic [POW_W-1:0] LIMIT = pow10(DIGITS);

   state_t             r_state;
   logic [CNT_W-1:0]   r_cnt;
   logic [BIN_W-1:0]   r_bin_q;
   logic [BIN_W-1:0]   r_bin_orig;
   logic [BCD_W-1:0]   r_scratch;
   logic [BCD_W-1:0]   r_bcd;
   logic               r_busy;
   logic               r_done;
   logic               r_ovf;

   logic [BCD_W-1:0]   w_adj;
   logic               w_start;
   logic               w_ovf;

   for (genvar g = 0; g < DIGITS; g++) begin : g_adj
      dd_digit_adj u_adj (
         .i_nib (r_scratch[4*g +: 4]),
         .o_nib (w_adj[4*g +: 4])
      );
   end

   assign w_start = bus.start | AUTO_RESTART;

   // Zero-extended compare: if 10^DIGITS exceeds the input range this is constantly 0.
   assign w_ovf = ({{(POW_W - BIN_W){1'b0}}, r_bin_orig} >= LIMIT);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state    <= S_IDLE;
         r_cnt      <= '0;
         r_bin_q    <= '0;
         r_bin_orig <= '0;
         r_scratch  <= '0;
         r_bcd      <= '0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_ovf      <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_start) begin
                  r_bin_q    <= bus.bin_in;
                  r_bin_orig <= bus.bin_in;
                  r_scratch  <= '0;
                  r_cnt      <= CNT_W'(BIN_W);
                  r_busy     <= 1'b1;
                  r_state    <= S_SHIFT;
               end
            end
            S_SHIFT: begin
               // Carry out of the top digit falls off the shift; ovf covers that case.
               {r_scratch, r_bin_q} <= {w_adj, r_bin_q} << 1;
               r_cnt <= r_cnt - CNT_W'(1);
               if (r_cnt == CNT_W'(1)) begin
                  r_state <= S_DONE;
               end
            end
            S_DONE: begin
               r_bcd   <= w_ovf ? {DIGITS{BCD_NINE}} : r_scratch;
               r_ovf   <= w_ovf;
               r_done  <= 1'b1;
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.bcd_out = r_bcd;
   assign bus.busy    = r_busy;
   assign bus.done    = r_done;
   assign bus.ovf     = r_ovf;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Bench for bin_to_bcd_seq: directed literal cases plus randomized traffic against a decimal model,
// with a second instance running in auto-restart mode on an incrementing input.
module tb_bin_to_bcd_seq;

   localparam longint unsigned LIMIT   = 64'd100000000;
   localparam int              LATENCY = 33;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;

   bin_to_bcd_seq_if bus ();
   bin_to_bcd_seq_if bus_a ();

   bin_to_bcd_seq #(.BIN_W(32), .DIGITS(8), .AUTO_RESTART(1'b0)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   bin_to_bcd_seq #(.BIN_W(32), .DIGITS(8), .AUTO_RESTART(1'b1)) u_auto (
      .clk (clk),
      .rst (rst),
      .bus (bus_a)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [31:0] bcd_of(input logic [31:0] v);
      logic [31:0]     r;
      longint unsigned x;
      x = 64'(v);
      r = '0;
      if (x >= LIMIT) return 32'h99999999;
      for (int i = 0; i < 8; i++) begin
         r[4*i +: 4] = 4'(x % 10);
         x = x / 10;
      end
      return r;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Behavioural model: a request accepted while idle yields its decimal image LATENCY edges later.
   logic [31:0] m_bcd = '0, ma_bcd = '0;
   logic        m_busy = 0, m_done = 0, m_ovf = 0;
   logic        ma_busy = 0, ma_done = 0, ma_ovf = 0;
   int          m_left = 0, ma_left = 0;
   logic [31:0] m_val = '0, ma_val = '0;

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_bcd = '0; m_busy = 0; m_done = 0; m_ovf = 0; m_left = 0;
      end else begin
         m_done = 0;
         if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin
               m_bcd  = bcd_of(m_val);
               m_ovf  = (64'(m_val) >= LIMIT);
               m_done = 1;
               m_busy = 0;
            end
         end else if (bus.start === 1'b1) begin
            m_val  = bus.bin_in;
            m_left = LATENCY;
            m_busy = 1;
         end
      end
   end

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         ma_bcd = '0; ma_busy = 0; ma_done = 0; ma_ovf = 0; ma_left = 0;
      end else begin
         ma_done = 0;
         if (ma_left > 0) begin
            ma_left--;
            if (ma_left == 0) begin
               ma_bcd  = bcd_of(ma_val);
               ma_ovf  = (64'(ma_val) >= LIMIT);
               ma_done = 1;
               ma_busy = 0;
            end
         end else begin
            ma_val  = bus_a.bin_in;
            ma_left = LATENCY;
            ma_busy = 1;
         end
      end
   end

   int a_last = 0;
   bit a_valid = 0;

   always @(negedge clk) begin
      chk("main_cycle", {29'd0, bus.ovf, bus.done, bus.busy, bus.bcd_out},
          {29'd0, m_ovf, m_done, m_busy, m_bcd});
      chk("auto_cycle", {29'd0, bus_a.ovf, bus_a.done, bus_a.busy, bus_a.bcd_out},
          {29'd0, ma_ovf, ma_done, ma_busy, ma_bcd});
      if (!rst) begin
         a_valid = 0;
      end else if (bus_a.done === 1'b1) begin
         if (a_valid) chk("auto_period", 64'(cyc - a_last), 64'd34);
         a_last  = cyc;
         a_valid = 1;
      end
   end

   initial begin
      bus_a.start  = 1'b0;
      bus_a.bin_in = 32'd99999000 + $urandom_range(0, 500);
      forever begin
         @(negedge clk);
         bus_a.bin_in = bus_a.bin_in + 32'd1;
      end
   end

   task automatic wait_done(output int busy_cycles, output bit ok);
      busy_cycles = 0;
      ok = 0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (bus.done === 1'b1) begin
            ok = 1;
            break;
         end
         if (bus.busy === 1'b1) busy_cycles++;
      end
   endtask

   task automatic run_conv(input string nm, input logic [31:0] v,
                           input logic [31:0] exp_bcd, input logic exp_ovf);
      int bc;
      bit ok;
      @(negedge clk);
      bus.bin_in = v;
      bus.start  = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      chk({nm, "_busy_start"}, 64'(bus.busy), 64'd1);
      wait_done(bc, ok);
      chk({nm, "_done_seen"}, 64'(ok), 64'd1);
      chk({nm, "_busy_len"}, 64'(bc + 1), 64'(LATENCY));
      chk({nm, "_bcd"}, 64'(bus.bcd_out), 64'(exp_bcd));
      chk({nm, "_ovf"}, 64'(bus.ovf), 64'(exp_ovf));
      @(negedge clk);
      chk({nm, "_done_1cyc"}, 64'(bus.done), 64'd0);
      chk({nm, "_idle"}, 64'(bus.busy), 64'd0);
   endtask

   initial begin
      int bc;
      bit ok;
      bus.bin_in = 32'd7;
      bus.start  = 1'b1;
      #1 rst = 1'b0;

      repeat (3) begin
         @(negedge clk);
         chk("reset_bcd", 64'(bus.bcd_out), 64'd0);
         chk("reset_flags", {61'd0, bus.busy, bus.done, bus.ovf}, 64'd0);
      end
      rst = 1'b1;
      @(negedge clk);
      chk("release_busy", 64'(bus.busy), 64'd1);
      bus.start = 1'b0;
      wait_done(bc, ok);
      chk("release_done_seen", 64'(ok), 64'd1);
      chk("release_bcd", 64'(bus.bcd_out), 64'h7);
      @(negedge clk);

      run_conv("conv_12345678", 32'd12345678, 32'h12345678, 1'b0);
      run_conv("conv_zero", 32'd0, 32'h00000000, 1'b0);
      run_conv("conv_max_ok", 32'd99999999, 32'h99999999, 1'b0);
      run_conv("conv_limit", 32'd100000000, 32'h99999999, 1'b1);
      run_conv("conv_all_ones", 32'hFFFFFFFF, 32'h99999999, 1'b1);

      // Start held high across two conversions, input changed mid-flight.
      @(negedge clk);
      bus.bin_in = 32'd42;
      bus.start  = 1'b1;
      repeat (5) @(negedge clk);
      bus.bin_in = 32'd77;
      wait_done(bc, ok);
      chk("held_first_seen", 64'(ok), 64'd1);
      chk("held_first_bcd", 64'(bus.bcd_out), 64'h42);
      @(negedge clk);
      chk("held_restart_busy", 64'(bus.busy), 64'd1);
      wait_done(bc, ok);
      chk("held_second_seen", 64'(ok), 64'd1);
      chk("held_second_bcd", 64'(bus.bcd_out), 64'h77);
      bus.start = 1'b0;
      @(negedge clk);
      chk("held_no_queue", 64'(bus.busy), 64'd0);

      // Reset in the middle of a conversion.
      @(negedge clk);
      bus.bin_in = 32'd555;
      bus.start  = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (9) @(negedge clk);
      #2 rst = 1'b0;
      #1;
      chk("rst_mid_bcd", 64'(bus.bcd_out), 64'd0);
      chk("rst_mid_flags", {61'd0, bus.busy, bus.done, bus.ovf}, 64'd0);
      repeat (3) begin
         @(negedge clk);
         chk("rst_mid_no_done", 64'(bus.done), 64'd0);
      end
      rst = 1'b1;
      run_conv("after_rst", 32'd555, 32'h00000555, 1'b0);

      // Randomized traffic; the per-cycle compare against the model does the checking.
      repeat (1500) begin
         @(negedge clk);
         case ($urandom_range(0, 3))
            0:       bus.bin_in = $urandom_range(0, 999);
            1:       bus.bin_in = $urandom_range(0, 99999999);
            2:       bus.bin_in = 32'd99999990 + $urandom_range(0, 20);
            default: bus.bin_in = $urandom();
         endcase
         bus.start = ($urandom_range(0, 5) == 0);
      end
      bus.start = 1'b0;

      ok = 0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (bus.busy === 1'b0 && bus.done === 1'b0) begin
            ok = 1;
            break;
         end
      end
      chk("final_idle", 64'(ok), 64'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
